// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    SCORED     = 3'd3,
    GAMEOVER   = 3'd4
  } state_e;

  localparam int   SCORE_W     = 3;
  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/tick_counter.sv
// Tick-enabled counter cleared by 'clear'; tc fires on the tick that completes
// 'target' counts, and the counter then restarts from zero.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  assign tc = en && (count_q == (target - W'(1)));

  // Next count: clear wins, otherwise advance on tick and wrap at terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tc) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong match controller: scoring, serve timing, ball re-centre handshake and
// match end. Optional game-over score flash is enabled by SCORE_FLASH_EN.
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int FLASH_TICKS = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               lmiss,
  input  logic               rmiss,
  input  logic               ball_ack,
  output logic [SCORE_W-1:0] Lscore,
  output logic [SCORE_W-1:0] Rscore,
  output logic               resetflag,
  output logic               serve,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner,
  output logic               display_blank
);

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_T = 8'(SERVE_TICKS);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
  logic               resetflag_q, resetflag_d, serve_q, serve_d;
  logic               serve_dir_q, serve_dir_d, game_over_q, game_over_d;
  logic               winner_q, winner_d, blank_q, blank_d;
  logic               serve_tc;

  tick_counter #(.W(8)) u_serve_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != SERVE_WAIT),
    .en     (tick),
    .target (SERVE_T),
    .tc     (serve_tc)
  );

`ifdef SCORE_FLASH_EN
  logic flash_tc;

  tick_counter #(.W(8)) u_flash_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != GAMEOVER),
    .en     (tick),
    .target (8'(FLASH_TICKS)),
    .tc     (flash_tc)
  );

  // Blank toggles only while staying in GAMEOVER, so it starts at 0 on entry.
  always_comb begin
    blank_d = 1'b0;
    if ((state_q == GAMEOVER) && (state_d == GAMEOVER)) begin
      blank_d = blank_q ^ flash_tc;
    end else begin
      blank_d = 1'b0;
    end
  end
`else
  // Flash disabled: the display is never blanked.
  always_comb begin
    blank_d = 1'b0;
  end
`endif

  // Match FSM next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    lscore_d    = lscore_q;
    rscore_d    = rscore_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    serve_d     = 1'b0;
    case (state_q)
      IDLE, GAMEOVER: begin
        if (start) begin
          lscore_d = '0;
          rscore_d = '0;
          state_d  = SERVE_WAIT;
        end else begin
          state_d  = state_q;
        end
      end
      SERVE_WAIT: begin
        if (serve_tc) begin
          serve_d = 1'b1;
          state_d = PLAY;
        end else begin
          state_d = SERVE_WAIT;
        end
      end
      PLAY: begin
        // A double miss is a replay: no point and serve direction kept.
        if (lmiss && rmiss) begin
          state_d = SCORED;
        end else if (rmiss) begin
          lscore_d    = lscore_q + SCORE_W'(1);
          serve_dir_d = SERVE_RIGHT;
          state_d     = SCORED;
        end else if (lmiss) begin
          rscore_d    = rscore_q + SCORE_W'(1);
          serve_dir_d = SERVE_LEFT;
          state_d     = SCORED;
        end else begin
          state_d = PLAY;
        end
      end
      SCORED: begin
        if (ball_ack) begin
          if ((lscore_q == WIN_S) || (rscore_q == WIN_S)) begin
            winner_d = (rscore_q == WIN_S);
            state_d  = GAMEOVER;
          end else begin
            state_d  = SERVE_WAIT;
          end
        end else begin
          state_d = SCORED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    resetflag_d = (state_d == SCORED);
    game_over_d = (state_d == GAMEOVER);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lscore_q    <= '0;
      rscore_q    <= '0;
      resetflag_q <= 1'b0;
      serve_q     <= 1'b0;
      serve_dir_q <= SERVE_LEFT;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lscore_q    <= lscore_d;
      rscore_q    <= rscore_d;
      resetflag_q <= resetflag_d;
      serve_q     <= serve_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      blank_q     <= blank_d;
    end
  end

  assign Lscore        = lscore_q;
  assign Rscore        = rscore_q;
  assign resetflag     = resetflag_q;
  assign serve         = serve_q;
  assign serve_dir     = serve_dir_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign display_blank = blank_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed self-checking bench for pong_score_ctrl (WIN_SCORE=4, SERVE_TICKS=3, FLASH_TICKS=2).
module tb_pong_score_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, start, lmiss, rmiss, ball_ack;
  logic [2:0] Lscore, Rscore;
  logic       resetflag, serve, serve_dir, game_over, winner, display_blank;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pong_score_ctrl #(
    .WIN_SCORE   (4),
    .SERVE_TICKS (3),
    .FLASH_TICKS (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .start         (start),
    .lmiss         (lmiss),
    .rmiss         (rmiss),
    .ball_ack      (ball_ack),
    .Lscore        (Lscore),
    .Rscore        (Rscore),
    .resetflag     (resetflag),
    .serve         (serve),
    .serve_dir     (serve_dir),
    .game_over     (game_over),
    .winner        (winner),
    .display_blank (display_blank)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int l, input int r, input int rf,
                         input int sv, input int sd, input int go, input int wn, input int db);
    chk({tag, ".Lscore"},        32'(Lscore),        32'(l));
    chk({tag, ".Rscore"},        32'(Rscore),        32'(r));
    chk({tag, ".resetflag"},     32'(resetflag),     32'(rf));
    chk({tag, ".serve"},         32'(serve),         32'(sv));
    chk({tag, ".serve_dir"},     32'(serve_dir),     32'(sd));
    chk({tag, ".game_over"},     32'(game_over),     32'(go));
    chk({tag, ".winner"},        32'(winner),        32'(wn));
    chk({tag, ".display_blank"}, 32'(display_blank), 32'(db));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; start = 1'b0;
    lmiss = 1'b0; rmiss = 1'b0; ball_ack = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(3);
    chk_all("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0);

    // 1: serve three edges after entering SERVE_WAIT
    start = 1'b1; cyc(1); start = 1'b0;
    chk("t1.serve_e0", 32'(serve), 32'd0);
    cyc(2);
    chk("t1.serve_e2", 32'(serve), 32'd0);
    cyc(1);
    chk_all("t1.serve_e3", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1);
    chk("t1.serve_once", 32'(serve), 32'd0);

    // 2: single point to the left player, held handshake
    rmiss = 1'b1; cyc(1); rmiss = 1'b0;
    chk_all("t2.point", 1, 0, 1, 0, 1, 0, 0, 0);
    cyc(5);
    chk("t2.rf_held", 32'(resetflag), 32'd1);
    ball_ack = 1'b1; cyc(1); ball_ack = 1'b0;
    chk("t2.rf_clear", 32'(resetflag), 32'd0);
    lmiss = 1'b1; cyc(1); lmiss = 1'b0;
    chk("t2.miss_ignored_R", 32'(Rscore), 32'd0);
    chk("t2.miss_ignored_rf", 32'(resetflag), 32'd0);
    cyc(1);
    chk("t2.serve_e2", 32'(serve), 32'd0);
    cyc(1);
    chk("t2.serve_e3", 32'(serve), 32'd1);

    // 3: simultaneous misses; ack already high on SCORED entry
    lmiss = 1'b1; rmiss = 1'b1; ball_ack = 1'b1; cyc(1);
    lmiss = 1'b0; rmiss = 1'b0;
    chk_all("t3.replay", 1, 0, 1, 0, 1, 0, 0, 0);
    cyc(1); ball_ack = 1'b0;
    chk("t3.rf_min1", 32'(resetflag), 32'd0);
    cyc(2);
    chk("t3.serve_e2", 32'(serve), 32'd0);
    cyc(1);
    chk("t3.serve_e3", 32'(serve), 32'd1);

    // 4: right player wins with four points
    for (int i = 0; i < 4; i++) begin
      lmiss = 1'b1; cyc(1); lmiss = 1'b0;
      chk("t4.Rscore", 32'(Rscore), 32'(i + 1));
      chk("t4.serve_dir", 32'(serve_dir), 32'd0);
      ball_ack = 1'b1; cyc(1); ball_ack = 1'b0;
      if (i < 3) begin
        chk("t4.no_gameover", 32'(game_over), 32'd0);
        cyc(2);
        cyc(1);
        chk("t4.serve", 32'(serve), 32'd1);
      end
    end
    chk_all("t4.gameover", 1, 4, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      lmiss = (k == 2); rmiss = (k == 4); ball_ack = (k == 5);
      cyc(1);
`ifdef SCORE_FLASH_EN
      chk("t6.blank", 32'(display_blank), 32'((k / 2) % 2));
`else
      chk("t6.blank", 32'(display_blank), 32'd0);
`endif
      chk("t4.frozen_L", 32'(Lscore), 32'd1);
      chk("t4.frozen_R", 32'(Rscore), 32'd4);
      chk("t4.still_over", 32'(game_over), 32'd1);
    end
    lmiss = 1'b0; rmiss = 1'b0; ball_ack = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("t4.restart", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(2);
    chk("t4.sw_e2", 32'(serve), 32'd0);
    cyc(1);
    chk("t4.sw_e3", 32'(serve), 32'd1);

    // 5: reset while in SCORED with Lscore = 3
    for (int i = 0; i < 3; i++) begin
      rmiss = 1'b1; cyc(1); rmiss = 1'b0;
      chk("t5.Lscore", 32'(Lscore), 32'(i + 1));
      if (i < 2) begin
        ball_ack = 1'b1; cyc(1); ball_ack = 1'b0;
        cyc(3);
        chk("t5.serve", 32'(serve), 32'd1);
      end
    end
    chk("t5.rf_before", 32'(resetflag), 32'd1);
    reset = 1'b1; ball_ack = 1'b1; cyc(1); reset = 1'b0;
    chk_all("t5.reset", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1); ball_ack = 1'b0;
    chk_all("t5.late_ack", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(5);
    chk_all("t5.idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // serve delay counts tick pulses, not clock cycles
    tick = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("tk.no_tick", 32'(serve), 32'd0);
    for (int j = 0; j < 2; j++) begin
      tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(2);
      chk("tk.partial", 32'(serve), 32'd0);
    end
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("tk.third", 32'(serve), 32'd1);
    cyc(1);
    chk("tk.pulse", 32'(serve), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
